// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM LED driver.
// GAMMA_LUT holds floor(255 * (i/255)^2.2), built at elaboration time.
package rgb_pwm_pkg;

  localparam int unsigned CLK_HZ    = 12_000_000;
  localparam int unsigned COLOR_W   = 8;
  localparam int unsigned LUT_DEPTH = 256;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } color_t;

  typedef logic [LUT_DEPTH-1:0][COLOR_W-1:0] gamma_lut_t;

  // Largest y with (y/255) <= (i/255)^2.2, i.e. y^5 * 255^6 <= i^11, by binary search.
  function automatic logic [7:0] gamma_entry(input int unsigned idx);
    logic [95:0] rhs;
    logic [95:0] k6;
    logic [95:0] y5;
    logic [8:0]  lo;
    logic [8:0]  hi;
    logic [8:0]  mid;
    rhs = 96'd1;
    k6  = 96'd1;
    for (int n = 0; n < 11; n++) rhs = rhs * 96'(idx);
    for (int n = 0; n < 6; n++) k6 = k6 * 96'd255;
    lo  = 9'd0;
    hi  = 9'd255;
    mid = 9'd0;
    for (int s = 0; s < 9; s++) begin
      if (lo < hi) begin
        mid = (lo + hi + 9'd1) >> 1;
        y5  = 96'd1;
        for (int n = 0; n < 5; n++) y5 = y5 * 96'(mid);
        if (y5 * k6 <= rhs) lo = mid;
        else hi = mid - 9'd1;
      end
    end
    return lo[7:0];
  endfunction

  function automatic gamma_lut_t build_gamma_lut();
    gamma_lut_t lut;
    lut = '0;
    for (int i = 0; i < 256; i++) lut[i] = gamma_entry(32'(i));
    return lut;
  endfunction

  localparam gamma_lut_t GAMMA_LUT = build_gamma_lut();

  function automatic logic [7:0] gamma8(input logic [7:0] x);
    return GAMMA_LUT[x];
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One LED channel: frame-synchronous duty register, compare against the
// shared PWM counter, and a registered active-low pin driver.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PWM_BITS-1:0] load_duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  logic [PWM_BITS-1:0] duty;
  logic                lit_c;

  assign lit_c = (pwm_cnt < duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= '0;
      led  <= 1'b1;
    end else begin
      if (load) duty <= load_duty;
      led <= !lit_c;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: valid/ready colour staging, frame-aligned duty load.
// Define GAMMA_EN to pass staged colours through the gamma-2.2 table at load.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 47,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                color_valid,
  output logic                color_ready,
  input  logic [PWM_BITS-1:0] color_r,
  input  logic [PWM_BITS-1:0] color_g,
  input  logic [PWM_BITS-1:0] color_b,
  output logic                frame_start,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

  if (CLK_DIV < 1) begin : g_div_check
    $error("CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                staged_full;
  logic                staged_next_c;
  logic [PWM_BITS-1:0] staged_r;
  logic [PWM_BITS-1:0] staged_g;
  logic [PWM_BITS-1:0] staged_b;
  logic [PWM_BITS-1:0] duty_r_c;
  logic [PWM_BITS-1:0] duty_g_c;
  logic [PWM_BITS-1:0] duty_b_c;
  logic                tick_c;
  logic                fb_c;
  logic                accept_c;
  logic                load_c;

  assign tick_c   = (div_cnt == DIV_LAST);
  assign fb_c     = tick_c && (pwm_cnt == PWM_MAX);
  assign accept_c = color_valid && color_ready;
  assign load_c   = fb_c && staged_full;

  // Load and accept are mutually exclusive: ready is low whenever staging is full.
  always_comb begin
    staged_next_c = staged_full;
    if (load_c) staged_next_c = 1'b0;
    else if (accept_c) staged_next_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      if (tick_c) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      staged_full <= 1'b0;
      color_ready <= 1'b0;
      frame_start <= 1'b0;
      staged_r    <= '0;
      staged_g    <= '0;
      staged_b    <= '0;
    end else begin
      staged_full <= staged_next_c;
      color_ready <= !staged_next_c;
      frame_start <= fb_c;
      if (accept_c) begin
        staged_r <= color_r;
        staged_g <= color_g;
        staged_b <= color_b;
      end
    end
  end

`ifdef GAMMA_EN
  if (PWM_BITS != 8) begin : g_gamma_check
    $error("GAMMA_EN requires PWM_BITS == 8");
  end
  assign duty_r_c = PWM_BITS'(gamma8(8'(staged_r)));
  assign duty_g_c = PWM_BITS'(gamma8(8'(staged_g)));
  assign duty_b_c = PWM_BITS'(gamma8(8'(staged_b)));
`else
  assign duty_r_c = staged_r;
  assign duty_g_c = staged_g;
  assign duty_b_c = staged_b;
`endif

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .load_duty(duty_r_c),
    .pwm_cnt  (pwm_cnt),
    .led      (RGB_R)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .load_duty(duty_g_c),
    .pwm_cnt  (pwm_cnt),
    .led      (RGB_G)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .load_duty(duty_b_c),
    .pwm_cnt  (pwm_cnt),
    .led      (RGB_B)
  );

endmodule
